sr_mem_arbiter: RTL and testbench
=================================

Name: sr_mem_arbiter

Overview:
- Shares one single-port, pipelined read memory between the CPU instruction-fetch port and the data-read port.
- Arbitrates one access per cycle and tags each accepted access with its source.
- Returns read data to the correct requester exactly LATENCY cycles after grant.
- Sits between sr_cpu (instr_addr/instr_data, data_addr/data_data) and a unified memory, enabling a von Neumann build of the core.

Parameters:
- ADDR_W, 32, address width of both requester ports and the memory port.
- DATA_W, 32, read data width.
- LATENCY, 1, memory read latency in cycles from mem_en to mem_rdata valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  instruction port read request.
- i_addr  in  ADDR_W  instruction port word address.
- i_gnt  out  1  instruction request accepted this cycle.
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  DATA_W  instruction read data.
- d_req  in  1  data port read request.
- d_addr  in  ADDR_W  data port word address.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid.
- d_rdata  out  DATA_W  data read data.
- mem_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_rdata  in  DATA_W  memory data, valid LATENCY cycles after mem_en.

Behaviour:
- Reset (rst low, asynchronous): tag pipeline cleared; i_rvalid=0, d_rvalid=0; rr_last=DATA, so the instruction port wins the first contention.
- While rst is low, i_gnt, d_gnt and mem_en are forced to 0.
- Grant is combinational, same cycle as the request. i_gnt and d_gnt are never both 1.
- mem_en = i_gnt | d_gnt.
- mem_addr = i_addr when i_gnt, d_addr when d_gnt, else 0.
- Only one requester active: it is granted every cycle it requests; back-to-back grants at full rate (1 per cycle).
- Both requesting, round-robin: the port not in rr_last is granted.
- rr_last updates on every grant to the granted port. It holds when no grant occurs.
- Requester rule: req and addr stay stable until gnt. The block does not latch unaccepted requests.
- Tag pipeline: LATENCY-deep shift register of {valid, src}. Stage 0 loads {mem_en, d_gnt} each cycle.
  - i_rvalid = last stage valid & src==INSTR.
  - d_rvalid = last stage valid & src==DATA.
  - Registered timing: gnt in cycle N gives rvalid in cycle N+LATENCY.
- i_rdata = d_rdata = mem_rdata (pass-through). Contents are meaningful only when the matching rvalid is 1.
- Ordering: responses return in grant order, at most one rvalid per cycle, no drops, no duplicates.
- Reset mid-operation: in-flight tags are discarded and no rvalid is produced for them after reset deasserts.
- LATENCY outside 1..4: elaboration error.

Optional Feature:
- Macro SR_ARB_DATA_PRIORITY_EN.
- Defined: fixed priority, data port always wins contention. rr_last is not implemented. The instruction port is granted only when d_req=0.
- Not defined: round-robin as specified above.
- Grant latency, the tag pipeline and reset behaviour are identical in both builds.

Test Plan:
- LATENCY=2, i_req=1 for 4 cycles at i_addr 0,1,2,3, d_req=0 -> i_gnt=1 each cycle; mem_addr 0,1,2,3; i_rvalid=1 in cycles 2..5 with mem_rdata of addresses 0..3; d_rvalid stays 0.
- First contention after reset (rst low then high), both req=1, i_addr=10, d_addr=20 -> i_gnt=1 first (mem_addr=10), then d_gnt=1 (mem_addr=20); both stay asserted and grants alternate I,D,I,D.
- Same contention with SR_ARB_DATA_PRIORITY_EN defined -> d_gnt=1 every cycle and i_gnt=0 until d_req drops; i_gnt=1 in the first cycle with d_req=0.
- LATENCY=3, d_gnt at cycle 5 then i_gnt at cycle 6 -> d_rvalid=1 at cycle 8 only, i_rvalid=1 at cycle 9 only; never both in one cycle.
- LATENCY=4, grants in cycles 0..2, rst pulsed low in cycle 3 for 1 cycle -> i_rvalid=d_rvalid=0 in all cycles after reset until new grants; rr_last restored to DATA.
- Idle, i_req=d_req=0 -> mem_en=0, mem_addr=0, no rvalid; rr_last unchanged, checked by the next contention.

Source files
------------

// File: rtl/sr_mem_arbiter.sv
// Two-port read arbiter sharing one pipelined memory between instruction fetch and data read.
// Optional build macro SR_ARB_DATA_PRIORITY_EN: data port wins every contention (no round-robin state).
module sr_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic SRC_INSTR = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("sr_mem_arbiter: LATENCY must be within 1..4");
        end
    endgenerate

    logic                i_gnt_s;
    logic                d_gnt_s;
    logic                mem_en_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [LATENCY-1:0]  tag_vld_d;
    logic [LATENCY-1:0]  tag_vld_q;
    logic [LATENCY-1:0]  tag_src_d;
    logic [LATENCY-1:0]  tag_src_q;

`ifdef SR_ARB_DATA_PRIORITY_EN
    // Grant decision: data port has fixed priority on contention.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!rst) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (i_req && d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            i_gnt_s = i_req;
            d_gnt_s = d_req;
        end
    end
`else
    logic rr_last_d;
    logic rr_last_q;

    // Grant decision: on contention the port that did not win last time is served.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!rst) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (i_req && d_req) begin
            if (rr_last_q == SRC_DATA) begin
                i_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else begin
            i_gnt_s = i_req;
            d_gnt_s = d_req;
        end
    end

    // Round-robin pointer follows the most recent winner and holds across idle cycles.
    always_comb begin
        rr_last_d = rr_last_q;
        if (i_gnt_s) begin
            rr_last_d = SRC_INSTR;
        end else if (d_gnt_s) begin
            rr_last_d = SRC_DATA;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Round-robin pointer register; reset favours the instruction port first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q <= SRC_DATA;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // Memory strobe and address mux.
    always_comb begin
        mem_en_s   = i_gnt_s | d_gnt_s;
        mem_addr_s = {ADDR_W{1'b0}};
        if (i_gnt_s) begin
            mem_addr_s = i_addr;
        end else if (d_gnt_s) begin
            mem_addr_s = d_addr;
        end else begin
            mem_addr_s = {ADDR_W{1'b0}};
        end
    end

    // Tag shift: stage 0 takes this cycle's grant, each later stage takes its predecessor.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_src_d    = tag_src_q;
        tag_vld_d[0] = mem_en_s;
        tag_src_d[0] = d_gnt_s;
        for (int i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_src_d[i] = tag_src_q[i-1];
        end
    end

    // Tag pipeline register; reset drops every in-flight response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_q <= {LATENCY{1'b0}};
            tag_src_q <= {LATENCY{1'b0}};
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_src_q <= tag_src_d;
        end
    end

    assign i_gnt    = i_gnt_s;
    assign d_gnt    = d_gnt_s;
    assign mem_en   = mem_en_s;
    assign mem_addr = mem_addr_s;
    assign i_rvalid = tag_vld_q[LATENCY-1] & (tag_src_q[LATENCY-1] == SRC_INSTR);
    assign d_rvalid = tag_vld_q[LATENCY-1] & (tag_src_q[LATENCY-1] == SRC_DATA);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Self-checking bench for sr_mem_arbiter: directed contention/reset sequences plus random traffic
// checked every cycle against a queue-based response model.
module tb_sr_mem_arbiter;

    localparam int LAT = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
`ifdef SR_ARB_DATA_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic          d_req = 1'b0;
    logic [AW-1:0] i_addr = 32'd0;
    logic [AW-1:0] d_addr = 32'd0;
    logic          i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en;
    logic [DW-1:0] i_rdata, d_rdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_cmp = 0;
    int n_err = 0;
    logic gi, gd;

    always #5 clk = ~clk;

    sr_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: data for the address presented LAT cycles earlier.
    logic [AW-1:0] addr_pipe [LAT];
    always @(posedge clk) begin
        addr_pipe[0] <= mem_addr;
        for (int k = 1; k < LAT; k++) addr_pipe[k] <= addr_pipe[k-1];
    end
    assign mem_rdata = mem_f(addr_pipe[LAT-1]);

    // Reference model: list of outstanding responses, each due LAT cycles after its grant.
    typedef struct {
        int          due;
        bit          is_d;
        logic [31:0] addr;
    } resp_t;
    resp_t pend[$];
    bit    last_d = 1'b1;
    int    cyc = 0;

    always @(negedge clk) begin : cmp
        bit          eg_i, eg_d, ev_i, ev_d;
        logic [31:0] ea, ed;
        resp_t       r;
        eg_i = 1'b0; eg_d = 1'b0; ev_i = 1'b0; ev_d = 1'b0;
        ed = 32'd0;
        if (!rst) begin
            pend.delete();
            last_d = 1'b1;
        end else if (i_req && d_req) begin
            if (PRIO || !last_d) eg_d = 1'b1;
            else eg_i = 1'b1;
        end else begin
            eg_i = i_req;
            eg_d = d_req;
        end
        ea = eg_i ? i_addr : (eg_d ? d_addr : 32'd0);
        chk("i_gnt", i_gnt, eg_i);
        chk("d_gnt", d_gnt, eg_d);
        chk("mem_en", mem_en, eg_i | eg_d);
        chk("mem_addr", mem_addr, ea);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            ev_i = !r.is_d;
            ev_d = r.is_d;
            ed = mem_f(r.addr);
        end
        chk("i_rvalid", i_rvalid, ev_i);
        chk("d_rvalid", d_rvalid, ev_d);
        if (ev_i) chk("i_rdata", i_rdata, ed);
        if (ev_d) chk("d_rdata", d_rdata, ed);
        if (eg_i || eg_d) begin
            pend.push_back(resp_t'{cyc + LAT, eg_d, ea});
            last_d = eg_d;
        end
        cyc++;
    end

    task automatic drive(input bit rs, input bit ir, input logic [31:0] ia,
                         input bit dr, input logic [31:0] da);
        @(posedge clk);
        #1;
        rst = rs; i_req = ir; i_addr = ia; d_req = dr; d_addr = da;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        // Reset held: grants forced off even with both requesting.
        drive(1'b0, 1'b1, 32'd10, 1'b1, 32'd20);
        chk("rst_i_gnt", i_gnt, 1'b0);
        chk("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        // First contention after reset.
        drive(1'b1, 1'b1, 32'd10, 1'b1, 32'd20);
        chk("c1_addr", mem_addr, PRIO ? 32'd20 : 32'd10);
        drive(1'b1, 1'b1, 32'd10, 1'b1, 32'd20);
        chk("c2_addr", mem_addr, 32'd20);
        drive(1'b1, 1'b1, 32'd10, 1'b1, 32'd20);
        chk("c3_addr", mem_addr, PRIO ? 32'd20 : 32'd10);
        drive(1'b1, 1'b1, 32'd10, 1'b0, 32'd0);
        chk("c4_i_gnt", i_gnt, 1'b1);
        chk("c4_i_rvalid", i_rvalid, !PRIO);
        chk("c4_d_rvalid", d_rvalid, PRIO);
        chk("c4_rdata", PRIO ? d_rdata : i_rdata, PRIO ? mem_f(32'd20) : mem_f(32'd10));
        // Idle cycles.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("idle_en", mem_en, 1'b0);
        chk("idle_addr", mem_addr, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        // Last winner was instruction: data wins the next contention in either build.
        drive(1'b1, 1'b1, 32'd11, 1'b1, 32'd21);
        chk("rr_hold_d_gnt", d_gnt, 1'b1);
        drive(1'b1, 1'b1, 32'd11, 1'b0, 32'd0);
        chk("rr_hold_i_gnt", i_gnt, 1'b1);
        // Grants in flight, then a reset pulse.
        drive(1'b1, 1'b1, 32'd30, 1'b1, 32'd40);
        chk("m0_d_gnt", d_gnt, 1'b1);
        drive(1'b1, 1'b1, 32'd30, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 32'd31, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("mrst_en", mem_en, 1'b0);
        for (int k = 0; k < LAT + 2; k++) begin
            drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
            chk("post_rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        end
        drive(1'b1, 1'b1, 32'd50, 1'b1, 32'd60);
        chk("post_rst_i_gnt", i_gnt, !PRIO);
        chk("post_rst_addr", mem_addr, PRIO ? 32'd60 : 32'd50);
        // Random traffic obeying the hold-until-granted rule, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            int dens;
            dens = 20 + 27 * ((n / 500) % 4);
            gi = i_gnt;
            gd = d_gnt;
            @(posedge clk);
            #1;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst = 1'b0;
            if (!i_req || gi) begin
                i_req  = ($urandom_range(0, 99) < dens);
                i_addr = $urandom;
            end
            if (!d_req || gd) begin
                d_req  = ($urandom_range(0, 99) < dens);
                d_addr = $urandom;
            end
            @(negedge clk);
        end
        gi = i_gnt;
        gd = d_gnt;
        for (int k = 0; k < LAT + 2; k++) drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("drained", pend.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
